// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - state encodings, OCW2 command codes and helpers for the PIC control sequencer
package pic_pkg;

   typedef enum logic [1:0] {
      CMD_READY = 2'd0,
      CMD_ICW2  = 2'd1,
      CMD_ICW3  = 2'd2,
      CMD_ICW4  = 2'd3
   } cmd_state_e;

   typedef enum logic [1:0] {
      CTRL_READY = 2'd0,
      CTRL_ACK1  = 2'd1,
      CTRL_ACK2  = 2'd2,
      CTRL_POLL  = 2'd3
   } ctrl_state_e;

   localparam logic [2:0] OCW2_AR_CLR    = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI    = 3'b001;
   localparam logic [2:0] OCW2_NOP       = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI    = 3'b011;
   localparam logic [2:0] OCW2_AR_SET    = 3'b100;
   localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
   localparam logic [2:0] OCW2_ROT_SPEOI = 3'b111;

   function automatic logic [7:0] pic_onehot8(input logic [2:0] id);
      return 8'b1 << id;
   endfunction

endpackage

// File: rtl/pic_onehot_encode.sv
// rtl/pic_onehot_encode.sv - one-hot level vector to encoded level id plus valid
module pic_onehot_encode #(
   parameter int  NUM_IRQ  = 8,
   localparam int IRQ_ID_W = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0]  onehot,
   output logic [IRQ_ID_W-1:0] id,
   output logic                valid
);

   // Input is one-hot, so OR-ing the indices of set bits yields the id.
   always_comb begin
      id = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (onehot[i]) id = id | IRQ_ID_W'(i);
      end
   end

   assign valid = |onehot;

endmodule

// File: rtl/pic_control_seq.sv
// rtl/pic_control_seq.sv - 8259-style init/command decode and INTA/poll sequencer
module pic_control_seq
   import pic_pkg::*;
#(
   parameter int  NUM_IRQ  = 8,
   localparam int IRQ_ID_W = $clog2(NUM_IRQ)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          data_bus,
   input  logic                write_ICW1,
   input  logic                write_ICW2_4,
   input  logic                write_OCW1,
   input  logic                write_OCW2,
   input  logic                write_OCW3,
   input  logic                read,
   input  logic                int_ack,
   input  logic                interrupt_pending,
   input  logic [NUM_IRQ-1:0]  highest_request,
   input  logic [NUM_IRQ-1:0]  highest_level_in_service,
   output logic                INT,
   output logic [NUM_IRQ-1:0]  int_mask,
   output logic [NUM_IRQ-1:0]  eoi,
   output logic                latch_in_service,
   output logic [IRQ_ID_W-1:0] priority_rotate,
   output logic                read_isr_or_irr,
   output logic                enable_read_register,
   output logic                level_or_edge_triggered,
   output logic                out_control_logic_data,
   output logic [7:0]          control_logic_data
);

   localparam int BASE_W = 8 - IRQ_ID_W;

   cmd_state_e  cmd_state_q, cmd_state_d;
   ctrl_state_e ctrl_state_q, ctrl_state_d;

   logic                ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
   logic                aeoi_q, aeoi_d, auto_rotate_q, auto_rotate_d;
   logic                rr_q, rr_d, int_q, int_d, latch_q, latch_d;
   logic                spurious_q, spurious_d, pending_q, pending_d;
   logic                int_ack_q, read_q;
   logic [NUM_IRQ-1:0]  int_mask_q, int_mask_d, eoi_q, eoi_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [IRQ_ID_W-1:0] prio_q, prio_d, ack_id_q, ack_id_d;

   logic [IRQ_ID_W-1:0] req_id, isr_id, lvl_id;
   logic                req_valid, isr_valid, lvl_ok, ocw_en, poll_cmd;
   logic                ack_rise, ack_fall, read_fall;
   logic [7:0]          lvl_oh, ack_oh;

   pic_onehot_encode #(.NUM_IRQ(NUM_IRQ)) u_req_enc (
      .onehot(highest_request), .id(req_id), .valid(req_valid)
   );
   pic_onehot_encode #(.NUM_IRQ(NUM_IRQ)) u_isr_enc (
      .onehot(highest_level_in_service), .id(isr_id), .valid(isr_valid)
   );

   assign ack_rise  = int_ack & ~int_ack_q;
   assign ack_fall  = ~int_ack & int_ack_q;
   assign read_fall = ~read & read_q;
   assign ocw_en    = (cmd_state_q == CMD_READY);
   assign poll_cmd  = ocw_en & write_OCW3 & data_bus[2];
   assign lvl_id    = data_bus[IRQ_ID_W-1:0];
   assign lvl_ok    = int'(data_bus[2:0]) < NUM_IRQ;
   assign lvl_oh    = pic_onehot8(3'(lvl_id));
   assign ack_oh    = pic_onehot8(3'(ack_id_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_state_q  <= CMD_READY;
         ctrl_state_q <= CTRL_READY;
         ltim_q <= 1'b0; sngl_q <= 1'b0; ic4_q <= 1'b0;
         aeoi_q <= 1'b0; auto_rotate_q <= 1'b0; rr_q <= 1'b0;
         int_q <= 1'b0; latch_q <= 1'b0; spurious_q <= 1'b0; pending_q <= 1'b0;
         int_ack_q <= 1'b0; read_q <= 1'b0;
         int_mask_q <= '1; eoi_q <= '0; base_q <= '0;
         prio_q <= IRQ_ID_W'(NUM_IRQ - 1); ack_id_q <= '0;
      end else begin
         cmd_state_q  <= cmd_state_d;
         ctrl_state_q <= ctrl_state_d;
         ltim_q <= ltim_d; sngl_q <= sngl_d; ic4_q <= ic4_d;
         aeoi_q <= aeoi_d; auto_rotate_q <= auto_rotate_d; rr_q <= rr_d;
         int_q <= int_d; latch_q <= latch_d; spurious_q <= spurious_d; pending_q <= pending_d;
         int_ack_q <= int_ack; read_q <= read;
         int_mask_q <= int_mask_d; eoi_q <= eoi_d; base_q <= base_d;
         prio_q <= prio_d; ack_id_q <= ack_id_d;
      end
   end

   always_comb begin
      cmd_state_d = cmd_state_q;
      if (write_ICW1) begin
         cmd_state_d = CMD_ICW2;
      end else if (write_ICW2_4) begin
         case (cmd_state_q)
            CMD_ICW2: cmd_state_d = !sngl_q ? CMD_ICW3 : (ic4_q ? CMD_ICW4 : CMD_READY);
            CMD_ICW3: cmd_state_d = ic4_q ? CMD_ICW4 : CMD_READY;
            CMD_ICW4: cmd_state_d = CMD_READY;
            default:  cmd_state_d = cmd_state_q;
         endcase
      end
   end

   // INTA rise takes precedence over a same-cycle poll command.
   always_comb begin
      ctrl_state_d = ctrl_state_q;
      if (write_ICW1) begin
         ctrl_state_d = CTRL_READY;
      end else begin
         case (ctrl_state_q)
            CTRL_READY: if (ack_rise) ctrl_state_d = CTRL_ACK1;
                        else if (poll_cmd) ctrl_state_d = CTRL_POLL;
            CTRL_ACK1:  if (ack_fall) ctrl_state_d = CTRL_ACK2;
            CTRL_ACK2:  if (ack_fall) ctrl_state_d = CTRL_READY;
            CTRL_POLL:  if (read_fall) ctrl_state_d = CTRL_READY;
            default:    ctrl_state_d = CTRL_READY;
         endcase
      end
   end

   always_comb begin
      ltim_d = ltim_q; sngl_d = sngl_q; ic4_d = ic4_q;
      aeoi_d = aeoi_q; auto_rotate_d = auto_rotate_q; rr_d = rr_q;
      spurious_d = spurious_q; pending_d = pending_q;
      int_mask_d = int_mask_q; base_d = base_q; prio_d = prio_q; ack_id_d = ack_id_q;
      eoi_d   = '0;
      latch_d = 1'b0;
      int_d   = interrupt_pending && (cmd_state_d == CMD_READY) && (ctrl_state_d == CTRL_READY);
      if (write_ICW1) begin
         ltim_d = data_bus[3]; sngl_d = data_bus[1]; ic4_d = data_bus[0];
         aeoi_d = 1'b0; auto_rotate_d = 1'b0; rr_d = 1'b0;
         int_mask_d = '1;
         eoi_d      = '1;
      end else begin
         if (write_ICW2_4 && cmd_state_q == CMD_ICW2) base_d = data_bus[7:IRQ_ID_W];
         if (write_ICW2_4 && cmd_state_q == CMD_ICW4) aeoi_d = data_bus[1];
         // Leaving READY means an INTA or poll cycle is starting: snapshot the winner.
         if (ctrl_state_q == CTRL_READY && ctrl_state_d != CTRL_READY) begin
            latch_d    = 1'b1;
            ack_id_d   = req_valid ? req_id : IRQ_ID_W'(NUM_IRQ - 1);
            spurious_d = !req_valid;
            pending_d  = interrupt_pending;
         end
         if (ctrl_state_q == CTRL_ACK2 && ack_fall && aeoi_q && !spurious_q) begin
            eoi_d = eoi_d | ack_oh[NUM_IRQ-1:0];
            if (auto_rotate_q) prio_d = ack_id_q;
         end
         if (ocw_en && write_OCW1) int_mask_d = data_bus[NUM_IRQ-1:0];
         if (ocw_en && write_OCW2) begin
            case (data_bus[7:5])
               OCW2_NS_EOI:    eoi_d = eoi_d | highest_level_in_service;
               OCW2_SP_EOI:    if (lvl_ok) eoi_d = eoi_d | lvl_oh[NUM_IRQ-1:0];
               OCW2_ROT_NSEOI: begin
                  eoi_d = eoi_d | highest_level_in_service;
                  if (isr_valid) prio_d = isr_id;
               end
               OCW2_ROT_SPEOI: if (lvl_ok) begin
                  eoi_d  = eoi_d | lvl_oh[NUM_IRQ-1:0];
                  prio_d = lvl_id;
               end
               OCW2_SET_PRIO:  if (lvl_ok) prio_d = lvl_id;
               OCW2_AR_SET:    auto_rotate_d = 1'b1;
               OCW2_AR_CLR:    auto_rotate_d = 1'b0;
               default:        ;
            endcase
         end
         if (ocw_en && write_OCW3 && data_bus[1] && !data_bus[2]) rr_d = data_bus[0];
      end
   end

   always_comb begin
      out_control_logic_data = 1'b0;
      control_logic_data     = 8'h00;
      if (ctrl_state_q == CTRL_ACK2 && int_ack) begin
         out_control_logic_data = 1'b1;
         control_logic_data     = {base_q, ack_id_q};
      end else if (ctrl_state_q == CTRL_POLL && read) begin
         out_control_logic_data = 1'b1;
         control_logic_data     = {pending_q, {(7 - IRQ_ID_W){1'b0}}, ack_id_q};
      end
   end

   assign enable_read_register    = read & (ctrl_state_q == CTRL_READY) & ~out_control_logic_data;
   assign INT                     = int_q;
   assign int_mask                = int_mask_q;
   assign eoi                     = eoi_q;
   assign latch_in_service        = latch_q;
   assign priority_rotate         = prio_q;
   assign read_isr_or_irr         = rr_q;
   assign level_or_edge_triggered = ltim_q;

endmodule

// File: tb/tb_pic_control_seq.sv
// tb/tb_pic_control_seq.sv - scoreboard bench for pic_control_seq with a behavioural PIC model
module tb_pic_control_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_bus = 8'h00;
   logic       write_ICW1 = 1'b0, write_ICW2_4 = 1'b0;
   logic       write_OCW1 = 1'b0, write_OCW2 = 1'b0, write_OCW3 = 1'b0;
   logic       read = 1'b0, int_ack = 1'b0, interrupt_pending = 1'b0;
   logic [7:0] highest_request = 8'h00, highest_level_in_service = 8'h00;
   logic       INT, latch_in_service, read_isr_or_irr, enable_read_register;
   logic       level_or_edge_triggered, out_control_logic_data;
   logic [7:0] int_mask, eoi, control_logic_data;
   logic [2:0] priority_rotate;

   pic_control_seq #(.NUM_IRQ(8)) dut (
      .clk(clk), .reset(reset), .data_bus(data_bus),
      .write_ICW1(write_ICW1), .write_ICW2_4(write_ICW2_4),
      .write_OCW1(write_OCW1), .write_OCW2(write_OCW2), .write_OCW3(write_OCW3),
      .read(read), .int_ack(int_ack), .interrupt_pending(interrupt_pending),
      .highest_request(highest_request), .highest_level_in_service(highest_level_in_service),
      .INT(INT), .int_mask(int_mask), .eoi(eoi), .latch_in_service(latch_in_service),
      .priority_rotate(priority_rotate), .read_isr_or_irr(read_isr_or_irr),
      .enable_read_register(enable_read_register),
      .level_or_edge_triggered(level_or_edge_triggered),
      .out_control_logic_data(out_control_logic_data), .control_logic_data(control_logic_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic       exp_latch_q[$];
   logic [7:0] exp_eoi_q[$];
   logic [7:0] exp_data_q[$];
   logic       prev_out = 1'b0;

   // Reference model state
   logic [7:0] m_mask = 8'hFF, m_base = 8'h00;
   logic [2:0] m_prio = 3'd7;
   logic       m_aeoi = 1'b0, m_ar = 1'b0, m_ready = 1'b1, m_sngl = 1'b0, m_ic4 = 1'b0;
   int         m_icw_left = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (latch_in_service) begin
         if (exp_latch_q.size() == 0) chk("latch_unexpected", 8'd1, 8'd0);
         else chk("latch", 8'd1, {7'd0, exp_latch_q.pop_front()});
      end
      if (eoi != 8'h00) begin
         if (exp_eoi_q.size() == 0) chk("eoi_unexpected", eoi, 8'h00);
         else chk("eoi", eoi, exp_eoi_q.pop_front());
      end
      if (out_control_logic_data && !prev_out) begin
         if (exp_data_q.size() == 0) chk("data_unexpected", control_logic_data, 8'h00);
         else chk("data", control_logic_data, exp_data_q.pop_front());
      end
      prev_out = out_control_logic_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1; int_ack = 1'b0; read = 1'b0;
      tick(); tick();
      reset = 1'b0;
      m_mask = 8'hFF; m_base = 8'h00; m_prio = 3'd7; m_aeoi = 1'b0; m_ar = 1'b0;
      m_ready = 1'b1; m_icw_left = 0;
   endtask

   task automatic wr_icw1(input logic [7:0] d);
      m_sngl = d[1]; m_ic4 = d[0]; m_aeoi = 1'b0; m_ar = 1'b0; m_mask = 8'hFF;
      m_ready = 1'b0; m_icw_left = 1 + (d[1] ? 0 : 1) + (d[0] ? 1 : 0);
      exp_eoi_q.push_back(8'hFF);
      data_bus = d; write_ICW1 = 1'b1; tick(); write_ICW1 = 1'b0;
   endtask

   // ICW2..ICW4 in order; the model tracks which word this write is.
   task automatic wr_icw(input logic [7:0] d);
      int total;
      total = 1 + (m_sngl ? 0 : 1) + (m_ic4 ? 1 : 0);
      if (m_icw_left == total) m_base = d & 8'hF8;
      else if (m_icw_left == 1 && m_ic4) m_aeoi = d[1];
      m_icw_left--;
      if (m_icw_left == 0) m_ready = 1'b1;
      data_bus = d; write_ICW2_4 = 1'b1; tick(); write_ICW2_4 = 1'b0;
   endtask

   task automatic wr_ocw1(input logic [7:0] d);
      if (m_ready) m_mask = d;
      data_bus = d; write_OCW1 = 1'b1; tick(); write_OCW1 = 1'b0;
   endtask

   task automatic wr_ocw2(input logic [7:0] d, input logic [7:0] isr);
      logic [7:0] lvl;
      lvl = 8'd1 << d[2:0];
      if (m_ready) begin
         case (d[7:5])
            3'b001: if (isr != 0) exp_eoi_q.push_back(isr);
            3'b011: exp_eoi_q.push_back(lvl);
            3'b101: if (isr != 0) begin exp_eoi_q.push_back(isr); m_prio = 3'(idx_of(isr)); end
            3'b111: begin exp_eoi_q.push_back(lvl); m_prio = d[2:0]; end
            3'b110: m_prio = d[2:0];
            3'b100: m_ar = 1'b1;
            3'b000: m_ar = 1'b0;
            default: ;
         endcase
      end
      highest_level_in_service = isr;
      data_bus = d; write_OCW2 = 1'b1; tick(); write_OCW2 = 1'b0;
      highest_level_in_service = 8'h00;
   endtask

   task automatic do_inta(input logic [7:0] req);
      int id;
      id = (req == 0) ? 7 : idx_of(req);
      exp_latch_q.push_back(1'b1);
      exp_data_q.push_back(m_base | 8'(id));
      if (m_aeoi && req != 0) begin
         exp_eoi_q.push_back(8'd1 << id);
         if (m_ar) m_prio = 3'(id);
      end
      highest_request = req; interrupt_pending = (req != 0);
      int_ack = 1'b1; tick(); tick();
      highest_request = 8'h00; interrupt_pending = 1'b0;
      int_ack = 1'b0; tick(); tick();
      int_ack = 1'b1; tick(); tick();
      int_ack = 1'b0; tick(); tick();
   endtask

   task automatic do_poll(input logic [7:0] req, input logic pend);
      int id;
      id = (req == 0) ? 7 : idx_of(req);
      exp_latch_q.push_back(1'b1);
      exp_data_q.push_back({pend, 4'b0000, 3'(id)});
      highest_request = req; interrupt_pending = pend;
      data_bus = 8'h0C; write_OCW3 = 1'b1; tick(); write_OCW3 = 1'b0;
      highest_request = 8'h00; interrupt_pending = 1'b0;
      read = 1'b1; tick(); tick();
      read = 1'b0; tick(); tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r8;
      do_reset();
      chk("rst_int_mask", int_mask, 8'hFF);
      chk("rst_prio", {5'd0, priority_rotate}, 8'd7);
      chk("rst_INT", {7'd0, INT}, 8'd0);
      chk("rst_rr", {7'd0, read_isr_or_irr}, 8'd0);
      chk("rst_out", {7'd0, out_control_logic_data}, 8'd0);

      // Init sequence; OCW2 mid-init must be ignored and INT held low
      wr_ocw1(8'h00);
      chk("ocw1_pre", int_mask, 8'h00);
      wr_icw1(8'h13);
      chk("icw1_mask", int_mask, 8'hFF);
      wr_icw(8'h40);
      wr_ocw2(8'h20, 8'h10);
      interrupt_pending = 1'b1; tick();
      chk("int_during_init", {7'd0, INT}, 8'd0);
      interrupt_pending = 1'b0;
      wr_icw(8'h03);
      chk("ltim", {7'd0, level_or_edge_triggered}, 8'd0);
      wr_ocw1(8'h5A);
      chk("ocw1_mask", int_mask, m_mask);
      interrupt_pending = 1'b1; tick();
      chk("int_ready", {7'd0, INT}, 8'd1);
      interrupt_pending = 1'b0; tick();
      chk("int_drop", {7'd0, INT}, 8'd0);

      do_inta(8'h04);
      wr_ocw2(8'h20, 8'h10);
      wr_ocw2(8'h63, 8'h00);
      wr_ocw2(8'hC5, 8'h00);
      chk("prio_c5", {5'd0, priority_rotate}, 8'd5);
      do_poll(8'h80, 1'b1);
      read = 1'b1; #1;
      chk("enable_rr", {7'd0, enable_read_register}, 8'd1);
      read = 1'b0; tick(); tick();
      data_bus = 8'h03; write_OCW3 = 1'b1; tick(); write_OCW3 = 1'b0;
      chk("ocw3_rr", {7'd0, read_isr_or_irr}, 8'd1);
      do_inta(8'h00);

      // Reset while in ACK2: no AEOI pulse, everything back to reset values
      exp_latch_q.push_back(1'b1);
      highest_request = 8'h02;
      int_ack = 1'b1; tick(); tick();
      int_ack = 1'b0; tick(); tick();
      highest_request = 8'h00;
      do_reset();
      tick();
      chk("rst_ack2_mask", int_mask, 8'hFF);
      chk("rst_ack2_prio", {5'd0, priority_rotate}, 8'd7);

      // ICW1 while in ACK1: control FSM back to READY
      exp_latch_q.push_back(1'b1);
      highest_request = 8'h08;
      int_ack = 1'b1; tick(); tick();
      highest_request = 8'h00;
      wr_icw1(8'h13);
      int_ack = 1'b0; tick(); tick();
      read = 1'b1; #1;
      chk("icw1_ack1_ready", {7'd0, enable_read_register}, 8'd1);
      read = 1'b0; tick();
      r8 = 8'($urandom_range(0, 255));
      wr_icw(r8);
      wr_icw(8'h03);
      wr_ocw2(8'h80, 8'h00);

      for (int it = 0; it < 80; it++) begin
         int op, sel;
         op  = $urandom_range(0, 3);
         sel = $urandom_range(0, 8);
         r8  = 8'($urandom_range(0, 255));
         case (op)
            0: begin wr_ocw1(r8); chk("rnd_mask", int_mask, m_mask); end
            1: begin
               wr_ocw2(r8, (sel == 8) ? 8'h00 : (8'd1 << sel));
               chk("rnd_prio_ocw2", {5'd0, priority_rotate}, {5'd0, m_prio});
            end
            2: begin
               do_inta((sel == 8) ? 8'h00 : (8'd1 << sel));
               chk("rnd_prio_inta", {5'd0, priority_rotate}, {5'd0, m_prio});
            end
            default: do_poll((sel == 8) ? 8'h00 : (8'd1 << sel), r8[0]);
         endcase
      end

      tick(); tick(); tick();
      chk("latch_left", 8'(exp_latch_q.size()), 8'd0);
      chk("eoi_left", 8'(exp_eoi_q.size()), 8'd0);
      chk("data_left", 8'(exp_data_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
